cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//   Multi-cycle control FSM for the CPU datapath. It fetches an instruction
//   from ROM, evaluates its condition against the VZCN flag register, and
//   sequences operand reads from the single-port register RAM, the ALU
//   execute step, and the RAM writeback. It owns the PC and the flag
//   register, and sits between the ROM, RAM and ALU instances inside CPU.
// PARAMETERS
//   PC_W    8   PC / ROM address width; PC wraps modulo 2**PC_W
//   INSTR_W 32  instruction width; field map below, bits [11:0] = imm
// PORTS
//   clock      in   1      system clock, all state changes on rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   run        in   1      1 = allowed to leave FETCH; sampled only in FETCH
//   rom_addr   out  PC_W   ROM read address (= pc)
//   rom_data   in   32     ROM data, combinational read of rom_addr
//   ram_addr   out  4      register-RAM address
//   ram_ce     out  1      RAM chip enable
//   ram_rw     out  1      1 = read, 0 = write
//   src1_le    out  1      datapath latches ram data into source1 at edge
//   src2_le    out  1      datapath latches ram data into source2 at edge
//   execute    out  1      ALU execute strobe
//   alu_op     out  4      opcode passed to the ALU
//   alu_flags  in   4      VZCN from the ALU, valid while execute=1
//   flags      out  4      registered VZCN flag register
//   state      out  3      current FSM state (debug / monitor)
//   halted     out  1      1 while in HALT
// BEHAVIOUR
//   Instruction fields:
//     [31:28] cond, [27:24] opcode, [23:20] dest, [19:16] sel1,
//     [15:12] sel2, [11:0] imm.
//   Reset (async, reset_n=0):
//     state=FETCH, pc=0, ir=0, flags=0000; ram_ce=0, ram_rw=1, src*_le=0,
//     execute=0, halted=0. Reset mid-instruction aborts at once, with no
//     RAM write and no PC or flag update.
//   States (one cycle each) and encodings:
//     FETCH=0, DECODE=1, READ1=2, READ2=3, EXEC=4, WRITE=5, HALT=6.
//   FETCH
//     - rom_addr=pc; ir<=rom_data.
//     - Goes to DECODE if run=1; otherwise holds in FETCH and ir is not loaded.
//   DECODE: cond is evaluated against the registered flags.
//     - Conditions: 0000 always; 0001 Z; 0010 !Z; 0011 C; 0100 !C; 0101 N;
//       0110 !N; 0111 V; 1000 !V. Every other code is never.
//     - cond false: pc<=pc+1, go to FETCH.
//     - opcode 1111 HALT: go to HALT, pc unchanged.
//     - opcode 1110 NOP: pc<=pc+1, go to FETCH.
//     - opcode 1101 BR: pc<=imm[PC_W-1:0], go to FETCH.
//     - All other opcodes: go to READ1.
//   READ1: ram_ce=1, ram_rw=1, ram_addr=sel1, src1_le=1.
//   READ2: ram_ce=1, ram_rw=1, ram_addr=sel2, src2_le=1.
//   EXEC
//     - execute=1, alu_op=opcode; flags<=alu_flags at the edge.
//     - opcode 1100 CMP: pc<=pc+1, go to FETCH (no writeback).
//     - Opcodes 0000-1011: go to WRITE.
//   WRITE: ram_ce=1, ram_rw=0, ram_addr=dest; pc<=pc+1, go to FETCH.
//   HALT: all strobes 0, halted=1; leaves only on reset.
//   Outside READ1/READ2/WRITE: ram_ce=0, ram_rw=1, ram_addr=0.
//   Outputs are decoded from the registered state and ir only (Moore);
//   they are glitch-free relative to the clock edge.
//   Latency:
//     - ALU op: 6 cycles.
//     - CMP: 5 cycles.
//     - BR / NOP / cond-fail: 2 cycles.
//   pc=2**PC_W-1 followed by pc+1 wraps to 0. A branch target wider than
//   PC_W is truncated.
//   Writeback to a dest equal to sel1/sel2 is legal: operands are already
//   latched before WRITE.
// TESTING
//   1. reset_n=0 mid-EXEC -> state=0, pc=0, flags=0000, ram_ce=0,
//      ram_rw=1 immediately, with no clock edge required.
//   2. ROM[0]=0x0_0_3_1_2_000 (ADD r3=r1+r2), r1=5, r2=7 ->
//      READ1 addr=1, READ2 addr=2, WRITE addr=3 with rw=0; pc=1 after
//      6 cycles.
//   3. CMP giving Z=1, then BR cond=0001 imm=0x020 -> pc=0x20; the same
//      branch with cond=0010 -> pc advances by 1, no RAM access.
//   4. PC_W=8, pc=0xFF holding NOP -> pc=0x00 after 2 cycles.
//   5. run=0 held 10 cycles in FETCH -> state stays 0, ram_ce=0,
//      pc unchanged; run=1 -> DECODE next cycle.
//   6. opcode 1111 -> halted=1, state=6 held for 20 cycles;
//      reset_n pulse -> FETCH, pc=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/read/execute/writeback controller
// owning the PC and the VZCN flag register; outputs are registered from next state.
module cpu_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [3:0]         ram_addr,
    output logic               ram_ce,
    output logic               ram_rw,
    output logic               src1_le,
    output logic               src2_le,
    output logic               execute,
    output logic [3:0]         alu_op,
    input  logic [3:0]         alu_flags,
    output logic [3:0]         flags,
    output logic [2:0]         state,
    output logic               halted
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        READ1  = 3'd2,
        READ2  = 3'd3,
        EXEC   = 3'd4,
        WRITE  = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [3:0]         flags_q, flags_d;
    logic [3:0]         ram_addr_q, ram_addr_d;
    logic               ram_ce_q, ram_ce_d;
    logic               ram_rw_q, ram_rw_d;
    logic               src1_le_q, src1_le_d;
    logic               src2_le_q, src2_le_d;
    logic               execute_q, execute_d;
    logic               halted_q, halted_d;
    logic               cond_ok;
    logic               unused_imm;

    wire [3:0] cond = ir_q[31:28];
    wire [3:0] opc  = ir_q[27:24];
    assign unused_imm = ^ir_q[11:0];

    // flags_q bit order is {V, Z, C, N}
    always_comb begin
        case (cond)
            4'b0000: cond_ok = 1'b1;
            4'b0001: cond_ok = flags_q[2];
            4'b0010: cond_ok = !flags_q[2];
            4'b0011: cond_ok = flags_q[1];
            4'b0100: cond_ok = !flags_q[1];
            4'b0101: cond_ok = flags_q[0];
            4'b0110: cond_ok = !flags_q[0];
            4'b0111: cond_ok = flags_q[3];
            4'b1000: cond_ok = !flags_q[3];
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        case (state_q)
            FETCH: if (run) begin
                ir_d    = rom_data;
                state_d = DECODE;
            end
            DECODE: begin
                if (!cond_ok || opc == 4'b1110) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end else if (opc == 4'b1111) begin
                    state_d = HALT;
                end else if (opc == 4'b1101) begin
                    pc_d    = ir_q[PC_W-1:0];
                    state_d = FETCH;
                end else begin
                    state_d = READ1;
                end
            end
            READ1: state_d = READ2;
            READ2: state_d = EXEC;
            EXEC: begin
                flags_d = alu_flags;
                if (opc == 4'b1100) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                pc_d    = pc_q + 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        // ir_d is the instruction that will be current when state_d is entered
        ram_ce_d   = state_d == READ1 || state_d == READ2 || state_d == WRITE;
        ram_rw_d   = state_d != WRITE;
        ram_addr_d = state_d == READ1 ? ir_d[19:16] :
                     state_d == READ2 ? ir_d[15:12] :
                     state_d == WRITE ? ir_d[23:20] : 4'd0;
        src1_le_d  = state_d == READ1;
        src2_le_d  = state_d == READ2;
        execute_d  = state_d == EXEC;
        halted_d   = state_d == HALT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            flags_q    <= 4'd0;
            ram_addr_q <= 4'd0;
            ram_ce_q   <= 1'b0;
            ram_rw_q   <= 1'b1;
            src1_le_q  <= 1'b0;
            src2_le_q  <= 1'b0;
            execute_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            ram_addr_q <= ram_addr_d;
            ram_ce_q   <= ram_ce_d;
            ram_rw_q   <= ram_rw_d;
            src1_le_q  <= src1_le_d;
            src2_le_q  <= src2_le_d;
            execute_q  <= execute_d;
            halted_q   <= halted_d;
        end
    end

    assign rom_addr = pc_q;
    assign ram_addr = ram_addr_q;
    assign ram_ce   = ram_ce_q;
    assign ram_rw   = ram_rw_q;
    assign src1_le  = src1_le_q;
    assign src2_le  = src2_le_q;
    assign execute  = execute_q;
    assign alu_op   = opc;
    assign flags    = flags_q;
    assign state    = state_q;
    assign halted   = halted_q;
endmodule
